// File: rtl/seg_mult_seq_pkg.sv
// Shared constants, state encoding and sizing helper for the sequential segmented multiplier.
package seg_mult_pkg;

    localparam int SEG_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_nseg(input int width);
        return width / SEG_W;
    endfunction

endpackage

// File: rtl/seg_mult_seq_if.sv
// Operand/product handshake bundle for seg_mult_seq.
interface seg_mult_seq_if #(
    parameter int WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 in_signed;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_p;

    modport master (
        output in_valid, in_a, in_b, in_signed, out_ready,
        input  in_ready, out_valid, out_p
    );

    modport slave (
        input  in_valid, in_a, in_b, in_signed, out_ready,
        output in_ready, out_valid, out_p
    );
endinterface

// File: rtl/seg_mult_seq_mult_8x8.sv
// Combinational 8x8 unsigned segment multiplier.
module mult_8x8 (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);
    assign p = {8'b0, a} * {8'b0, b};
endmodule

// File: rtl/seg_mult_seq.sv
// Sequential WIDTHxWIDTH multiplier: one 8x8 partial product per clock, shifted into a 2*WIDTH accumulator.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// CALC  | accumulating partial products, NSEG*NSEG cycles
// DONE  | product held on out_p until out_ready
module seg_mult_seq
    import seg_mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    seg_mult_seq_if.slave bus
);
    localparam int NSEG = calc_nseg(WIDTH);
    localparam int CW   = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam int PW   = 2 * WIDTH;
    localparam logic [CW-1:0] LAST = CW'(NSEG - 1);

    generate
        if ((WIDTH % SEG_W) != 0 || WIDTH < SEG_W) begin : g_bad_width
            $error("seg_mult_seq: WIDTH must be a multiple of 8 and at least 8");
        end
    endgenerate

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               neg;
    logic [PW-1:0]      acc;
    logic [PW-1:0]      p_q;
    logic [CW-1:0]      i_cnt, j_cnt;
    logic [SEG_W-1:0]   a_seg, b_seg;
    logic [2*SEG_W-1:0] pp;
    logic [PW-1:0]      pp_sh, sum;
    logic               accept, last;

    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = (state == DONE);
    assign bus.out_p     = p_q;

    assign accept = bus.in_valid && bus.in_ready;
    assign last   = (state == CALC) && (i_cnt == LAST) && (j_cnt == LAST);

    // Constant-index mux keeps every select in range, including NSEG = 1.
    always_comb begin
        a_seg = '0;
        b_seg = '0;
        for (int k = 0; k < NSEG; k++) begin
            if (int'(i_cnt) == k) a_seg = a_mag[k*SEG_W +: SEG_W];
            if (int'(j_cnt) == k) b_seg = b_mag[k*SEG_W +: SEG_W];
        end
    end

    mult_8x8 u_mult (
        .a (a_seg),
        .b (b_seg),
        .p (pp)
    );

    assign pp_sh = PW'(pp) << (SEG_W * (int'(i_cnt) + int'(j_cnt)));
    assign sum   = acc + pp_sh;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = CALC;
            CALC:    if (last) state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_mag <= '0;
            b_mag <= '0;
            neg   <= 1'b0;
            acc   <= '0;
            p_q   <= '0;
            i_cnt <= '0;
            j_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        // Negating the most negative value yields 2^(WIDTH-1), still exact unsigned.
                        a_mag <= (bus.in_signed && bus.in_a[WIDTH-1]) ? -bus.in_a : bus.in_a;
                        b_mag <= (bus.in_signed && bus.in_b[WIDTH-1]) ? -bus.in_b : bus.in_b;
                        neg   <= bus.in_signed & (bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1]);
                        acc   <= '0;
                        i_cnt <= '0;
                        j_cnt <= '0;
                    end
                end
                CALC: begin
                    acc <= sum;
                    if (i_cnt == LAST) begin
                        i_cnt <= '0;
                        j_cnt <= j_cnt + CW'(1);
                    end else begin
                        i_cnt <= i_cnt + CW'(1);
                    end
                    if (last) p_q <= neg ? -sum : sum;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_mult_seq.sv
// Directed self-checking bench for seg_mult_seq at WIDTH=32 and WIDTH=8.
module tb_seg_mult_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg_mult_seq_if #(.WIDTH(32)) b32 ();
    seg_mult_seq_if #(.WIDTH(8))  b8 ();

    seg_mult_seq #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(b32));
    seg_mult_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(b8));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start32(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clk);
        b32.in_a      = a;
        b32.in_b      = b;
        b32.in_signed = s;
        b32.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        b32.in_valid  = 1'b0;
    endtask

    task automatic wait_done32(output int lat);
        lat = 0;
        while (b32.out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume32();
        @(negedge clk);
        b32.out_ready = 1'b1;
        @(posedge clk);
        #1;
        b32.out_ready = 1'b0;
    endtask

    // Full transaction on either instance; returns product and accept-to-valid edge count.
    task automatic mul(input bit w8, input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [63:0] p, output int lat);
        if (!w8) begin
            start32(a, b, s);
            wait_done32(lat);
            p = b32.out_p;
            consume32();
        end else begin
            @(negedge clk);
            b8.in_a      = a[7:0];
            b8.in_b      = b[7:0];
            b8.in_signed = s;
            b8.in_valid  = 1'b1;
            @(posedge clk);
            #1;
            b8.in_valid  = 1'b0;
            lat = 0;
            while (b8.out_valid !== 1'b1 && lat < 200) begin
                @(posedge clk);
                #1;
                lat++;
            end
            p = {48'b0, b8.out_p};
            @(negedge clk);
            b8.out_ready = 1'b1;
            @(posedge clk);
            #1;
            b8.out_ready = 1'b0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] p;
        int          lat;

        rst = 1'b1;
        b32.in_valid = 1'b0; b32.in_a = '0; b32.in_b = '0; b32.in_signed = 1'b0; b32.out_ready = 1'b0;
        b8.in_valid  = 1'b0; b8.in_a  = '0; b8.in_b  = '0; b8.in_signed  = 1'b0; b8.out_ready  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready32", {63'b0, b32.in_ready}, 64'd0);
        chk("rst_out_valid32", {63'b0, b32.out_valid}, 64'd0);
        chk("rst_out_p32", b32.out_p, 64'd0);
        chk("rst_in_ready8", {63'b0, b8.in_ready}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready32", {63'b0, b32.in_ready}, 64'd1);
        chk("post_rst_in_ready8", {63'b0, b8.in_ready}, 64'd1);

        mul(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, p, lat);
        chk("u_ffff_sq", p, 64'hFFFF_FFFE_0000_0001);
        chk("u_ffff_lat", 64'(lat), 64'd16);

        mul(1'b0, 32'hFFFF_FFFD, 32'h0000_0007, 1'b1, p, lat);
        chk("s_m3x7", p, 64'hFFFF_FFFF_FFFF_FFEB);
        mul(1'b0, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0, p, lat);
        chk("u_m3x7", p, 64'h0000_0006_FFFF_FFEB);
        mul(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b1, p, lat);
        chk("s_min_sq", p, 64'h4000_0000_0000_0000);
        mul(1'b0, 32'h8000_0000, 32'h0000_0001, 1'b1, p, lat);
        chk("s_min_x1", p, 64'hFFFF_FFFF_8000_0000);

        // Backpressure with a competing operand pair held on the input.
        start32(32'd5, 32'd9, 1'b0);
        wait_done32(lat);
        chk("bp_first_p", b32.out_p, 64'd45);
        @(negedge clk);
        b32.in_a = 32'd7; b32.in_b = 32'd11; b32.in_signed = 1'b0; b32.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("bp_out_valid", {63'b0, b32.out_valid}, 64'd1);
            chk("bp_in_ready", {63'b0, b32.in_ready}, 64'd0);
            chk("bp_out_p", b32.out_p, 64'd45);
        end
        @(negedge clk);
        b32.out_ready = 1'b1;
        @(posedge clk);
        #1;
        b32.out_ready = 1'b0;
        chk("bp_hs_in_ready", {63'b0, b32.in_ready}, 64'd1);
        chk("bp_hs_out_valid", {63'b0, b32.out_valid}, 64'd0);
        @(posedge clk);
        #1;
        b32.in_valid = 1'b0;
        chk("bp_next_accept", {63'b0, b32.in_ready}, 64'd0);
        wait_done32(lat);
        chk("bp_next_lat", 64'(lat), 64'd16);
        chk("bp_next_p", b32.out_p, 64'd77);
        consume32();

        // Abort mid-calculation after 7 iterations.
        start32(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_out_valid", {63'b0, b32.out_valid}, 64'd0);
        chk("abort_out_p", b32.out_p, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_in_ready", {63'b0, b32.in_ready}, 64'd1);
        mul(1'b0, 32'd2, 32'd3, 1'b0, p, lat);
        chk("abort_follow_p", p, 64'd6);
        chk("abort_follow_lat", 64'(lat), 64'd16);

        mul(1'b1, 32'hFF, 32'hFF, 1'b0, p, lat);
        chk("w8_u_ff_sq", p, 64'hFE01);
        chk("w8_u_lat", 64'(lat), 64'd1);
        mul(1'b1, 32'hFF, 32'hFF, 1'b1, p, lat);
        chk("w8_s_m1_sq", p, 64'h0001);
        mul(1'b1, 32'h80, 32'h7F, 1'b1, p, lat);
        chk("w8_s_min_x7f", p, 64'hC080);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
